logic_op_stage: RTL and testbench

//  Registered bitwise-logic execute stage with valid/ready handshake on both sides.

---
 rtl/logic_op_stage.sv | 163 ++++++++++++++++
 tb/tb_logic_op_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_stage.sv
// ---------------------------------------------------------------------------
// logic_op_stage
//
// Registered bitwise-logic execute stage. Operand pairs arrive from decode
// with a 2-bit opcode and a tag; the stage computes AND/OR/XOR/NOR at accept
// time, stores only the result (plus zero flag and tag), and presents it to
// the downstream consumer over a valid/ready handshake.
//
// A main register drives out_* and a skid register absorbs one extra beat,
// so the stage sustains one beat per cycle while in_ready stays a registered
// signal (no combinational path from out_ready back to decode).
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous reset, active-low
//   in_valid    operand beat valid
//   in_ready    stage can accept a beat (registered)
//   in_a        operand A            [WIDTH]
//   in_b        operand B            [WIDTH]
//   in_op       00 AND, 01 OR, 10 XOR, 11 NOR
//   in_tag      tag carried with the beat [TAG_W]
//   out_valid   result beat valid
//   out_ready   downstream accepts the result
//   out_result  computed result      [WIDTH]
//   out_zero    1 iff out_result == 0
//   out_tag     tag of the result beat [TAG_W]
// ---------------------------------------------------------------------------
module logic_op_stage #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state_reg;
  logic             in_ready_reg;

  logic [WIDTH-1:0] main_result_reg;
  logic             main_zero_reg;
  logic [TAG_W-1:0] main_tag_reg;

  logic [WIDTH-1:0] skid_result_reg;
  logic             skid_zero_reg;
  logic [TAG_W-1:0] skid_tag_reg;

  logic [WIDTH-1:0] op_result;
  logic             op_zero;
  logic             in_fire;
  logic             out_fire;

  // Per-bit logic unit. The result vector is exactly WIDTH bits, so NOR is
  // inherently confined to the operand width.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign op_result[gi] = (in_op == OP_AND) ? (in_a[gi] & in_b[gi]) :
                             (in_op == OP_OR)  ? (in_a[gi] | in_b[gi]) :
                             (in_op == OP_XOR) ? (in_a[gi] ^ in_b[gi]) :
                                                 ~(in_a[gi] | in_b[gi]);
    end
  endgenerate

  // Zero flag is captured alongside the result so that it is 0 at reset,
  // independent of the cleared result register.
  assign op_zero  = ~|op_result;

  assign in_fire  = in_valid & in_ready_reg;
  assign out_fire = out_valid & out_ready;

  // Control and storage. in_ready_reg is written with the value matching the
  // state being entered, so it always reflects the current state one cycle
  // later without any combinational ready path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_EMPTY;
      in_ready_reg    <= 1'b1;
      main_result_reg <= '0;
      main_zero_reg   <= 1'b0;
      main_tag_reg    <= '0;
      skid_result_reg <= '0;
      skid_zero_reg   <= 1'b0;
      skid_tag_reg    <= '0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (in_fire) begin
            main_result_reg <= op_result;
            main_zero_reg   <= op_zero;
            main_tag_reg    <= in_tag;
            state_reg       <= ST_ONE;
            in_ready_reg    <= 1'b1;
          end
        end

        ST_ONE: begin
          if (in_fire && !out_fire) begin
            // Main is still waiting downstream; park the new beat in skid.
            skid_result_reg <= op_result;
            skid_zero_reg   <= op_zero;
            skid_tag_reg    <= in_tag;
            state_reg       <= ST_TWO;
            in_ready_reg    <= 1'b0;
          end else if (in_fire && out_fire) begin
            // Main drains and refills in the same cycle: no bubble.
            main_result_reg <= op_result;
            main_zero_reg   <= op_zero;
            main_tag_reg    <= in_tag;
            state_reg       <= ST_ONE;
            in_ready_reg    <= 1'b1;
          end else if (out_fire) begin
            state_reg       <= ST_EMPTY;
            in_ready_reg    <= 1'b1;
          end
        end

        ST_TWO: begin
          // in_ready_reg is 0 here, so only the drain can happen.
          if (out_fire) begin
            main_result_reg <= skid_result_reg;
            main_zero_reg   <= skid_zero_reg;
            main_tag_reg    <= skid_tag_reg;
            state_reg       <= ST_ONE;
            in_ready_reg    <= 1'b1;
          end
        end

        default: begin
          state_reg    <= ST_EMPTY;
          in_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_reg;
  assign out_valid  = (state_reg != ST_EMPTY);
  assign out_result = main_result_reg;
  assign out_zero   = main_zero_reg;
  assign out_tag    = main_tag_reg;

endmodule

// File: tb/tb_logic_op_stage.sv
module tb_logic_op_stage;

  localparam int WIDTH = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  logic_op_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_tag    (out_tag)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  // Advance one clock and settle just past the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [1:0] op, input logic [TAG_W-1:0] tag);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_tag   = tag;
  endtask

  logic [WIDTH-1:0] op_exp [4];

  initial begin
    op_exp[0] = 32'h00F0_000F;  // AND
    op_exp[1] = 32'hFFF0_0FFF;  // OR
    op_exp[2] = 32'hFF00_0FF0;  // XOR
    op_exp[3] = 32'h000F_F000;  // NOR

    // ---- reset with in_valid held high ----
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 5'd3);
    step();
    step();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_result", {32'd0, out_result}, 64'd0);
    check("rst_out_zero", {63'd0, out_zero}, 64'd0);
    check("rst_out_tag", {59'd0, out_tag}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // first cycle after release accepts a beat
    rst_n     = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, 32'hF0F0_00FF, 32'h0FF0_0F0F, 2'b00, 5'd9);
    step();
    check("post_rst_valid", {63'd0, out_valid}, 64'd1);
    check("post_rst_result", {32'd0, out_result}, {32'd0, 32'h00F0_000F});
    check("post_rst_tag", {59'd0, out_tag}, 64'd9);

    // reset asserted mid-cycle takes effect only at the next edge
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    check("async_rst_hold_valid", {63'd0, out_valid}, 64'd1);
    check("async_rst_hold_tag", {59'd0, out_tag}, 64'd9);
    step();
    check("async_rst_edge_valid", {63'd0, out_valid}, 64'd0);
    check("async_rst_edge_tag", {59'd0, out_tag}, 64'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // ---- op coverage ----
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hF0F0_00FF, 32'h0FF0_0F0F, i[1:0], i[TAG_W-1:0]);
      step();
      check($sformatf("op%0d_result", i), {32'd0, out_result}, {32'd0, op_exp[i]});
      check($sformatf("op%0d_zero", i), {63'd0, out_zero}, 64'd0);
      check($sformatf("op%0d_tag", i), {59'd0, out_tag}, i);
    end
    drive(1'b1, 32'h0, 32'h0, 2'b00, 5'd5);
    step();
    check("zero_result", {32'd0, out_result}, 64'd0);
    check("zero_flag", {63'd0, out_zero}, 64'd1);
    in_valid = 1'b0;
    step();
    check("op_drain_valid", {63'd0, out_valid}, 64'd0);

    // ---- streaming 8 beats ----
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h1000_0000 + i, 32'h0, 2'b01, i[TAG_W-1:0]);
      step();
      check($sformatf("stream%0d_valid", i), {63'd0, out_valid}, 64'd1);
      check($sformatf("stream%0d_tag", i), {59'd0, out_tag}, i);
      check($sformatf("stream%0d_result", i), {32'd0, out_result}, 64'h1000_0000 + i);
      check($sformatf("stream%0d_in_ready", i), {63'd0, in_ready}, 64'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drain_valid", {63'd0, out_valid}, 64'd0);

    // ---- backpressure ----
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_1111, 32'h0, 2'b01, 5'd1);
    step();
    check("bp_t1_tag", {59'd0, out_tag}, 64'd1);
    check("bp_t1_in_ready", {63'd0, in_ready}, 64'd1);
    drive(1'b1, 32'h0000_2222, 32'h0, 2'b01, 5'd2);
    step();
    check("bp_t2_in_ready", {63'd0, in_ready}, 64'd0);
    check("bp_t2_hold_tag", {59'd0, out_tag}, 64'd1);
    drive(1'b1, 32'h0000_3333, 32'h0, 2'b01, 5'd3);
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("bp_stall%0d_tag", i), {59'd0, out_tag}, 64'd1);
      check($sformatf("bp_stall%0d_result", i), {32'd0, out_result}, 64'h1111);
      check($sformatf("bp_stall%0d_in_ready", i), {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    step();
    check("bp_out2_tag", {59'd0, out_tag}, 64'd2);
    check("bp_out2_result", {32'd0, out_result}, 64'h2222);
    check("bp_out2_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    check("bp_out3_tag", {59'd0, out_tag}, 64'd3);
    check("bp_out3_result", {32'd0, out_result}, 64'h3333);
    in_valid = 1'b0;
    step();
    check("bp_drain_valid", {63'd0, out_valid}, 64'd0);

    // ---- simultaneous accept and drain in ONE ----
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_000A, 32'h0, 2'b01, 5'd10);
    step();
    check("sim_t10_tag", {59'd0, out_tag}, 64'd10);
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_000B, 32'h0, 2'b01, 5'd11);
    step();
    check("sim_t11_valid", {63'd0, out_valid}, 64'd1);
    check("sim_t11_tag", {59'd0, out_tag}, 64'd11);
    check("sim_t11_in_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b0;
    step();
    check("sim_drain_valid", {63'd0, out_valid}, 64'd0);

    // ---- reset while holding two beats ----
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0014, 32'h0, 2'b01, 5'd20);
    step();
    drive(1'b1, 32'h0000_0015, 32'h0, 2'b01, 5'd21);
    step();
    check("mid_two_in_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("mid_rst_gone%0d", i), {63'd0, out_valid}, 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
